// File: rtl/sevenseg_scan_ctrl_if.sv
// Load handshake, display controls and pin outputs
// of the scanned seven-segment driver.
interface sevenseg_scan_ctrl_if #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 16
);
    logic [BIN_W-1:0]    bin_in;
    logic                load;
    logic                ready;
    logic [1:0]          mode;
    logic                lz_blank;
    logic                ovf;
    logic [N_DIGITS-1:0] an;
    logic [6:0]          seg;

    modport master (
        output bin_in, load, mode, lz_blank,
        input  ready, ovf, an, seg
    );

    modport slave (
        input  bin_in, load, mode, lz_blank,
        output ready, ovf, an, seg
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Binary-to-BCD (shift-add-3) converter feeding a
// time-multiplexed N-digit seven-segment scanner.
module sevenseg_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int BIN_W       = 16,
    parameter int SCAN_DIV    = 50000,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    sevenseg_scan_ctrl_if.slave bus
);

    localparam int BCD_CALC = (BIN_W * 302 + 999) / 1000 + 1;
    localparam int BCD_D    = (BCD_CALC < N_DIGITS) ? N_DIGITS : BCD_CALC;
    localparam int BCD_W    = BCD_D * 4;
    localparam int DISP_W   = N_DIGITS * 4;
    localparam int CNT_W    = $clog2(BIN_W);
    localparam int IDX_W    = $clog2(N_DIGITS);
    localparam int PRE_W    = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    localparam logic [6:0] G_DASH  = 7'b0000001;
    localparam logic [6:0] G_BLANK = 7'b0000000;
    localparam logic [6:0] G_ALL   = 7'b1111111;

    localparam logic [6:0] SEG_OFF =
        SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF =
        AN_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t              r_state;
    logic [BIN_W-1:0]    r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic [DISP_W-1:0]   r_disp;
    logic                r_ovf;
    logic                r_ready;
    logic [PRE_W-1:0]    r_pre;
    logic [IDX_W-1:0]    r_idx;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;

    logic [BCD_W-1:0]    w_adj;
    logic                w_hi_nz;
    logic [3:0]          w_nib;
    logic                w_zero_up;
    logic                w_lz;
    logic [6:0]          w_glyph;
    logic [N_DIGITS-1:0] w_onehot;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'd0:    f_glyph = 7'b1111110;
            4'd1:    f_glyph = 7'b0110000;
            4'd2:    f_glyph = 7'b1101101;
            4'd3:    f_glyph = 7'b1111001;
            4'd4:    f_glyph = 7'b0110011;
            4'd5:    f_glyph = 7'b1011011;
            4'd6:    f_glyph = 7'b1011111;
            4'd7:    f_glyph = 7'b1110000;
            4'd8:    f_glyph = 7'b1111111;
            4'd9:    f_glyph = 7'b1111011;
            default: f_glyph = 7'b0000000;
        endcase
    endfunction

    // Add-3 correction of every BCD nibble ahead of the next shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_D; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    generate
        if (BCD_D > N_DIGITS) begin : g_hi
            assign w_hi_nz = |r_bcd[BCD_W-1:DISP_W];
        end else begin : g_no_hi
            assign w_hi_nz = 1'b0;
        end
    endgenerate

    // Conversion FSM: capture, BIN_W shift steps, then commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_bin   <= bus.bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_disp  <= r_bcd[DISP_W-1:0];
                    r_ovf   <= w_hi_nz;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Prescaler and digit scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Glyph for the current slot from mode, overflow and blanking
    always_comb begin
        w_nib     = 4'd0;
        w_zero_up = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib = r_disp[i*4 +: 4];
            end
            if (IDX_W'(i) >= r_idx && r_disp[i*4 +: 4] != 4'd0) begin
                w_zero_up = 1'b0;
            end
        end
        w_lz     = bus.lz_blank && (r_idx != '0) && w_zero_up;
        w_onehot = N_DIGITS'(1) << r_idx;
        w_glyph  = G_BLANK;
        unique case (bus.mode)
            2'd0: begin
                if (r_ovf) begin
                    w_glyph = G_DASH;
                end else if (w_lz) begin
                    w_glyph = G_BLANK;
                end else begin
                    w_glyph = f_glyph(w_nib);
                end
            end
            2'd1:    w_glyph = G_DASH;
            2'd2:    w_glyph = G_BLANK;
            default: w_glyph = G_ALL;
        endcase
    end

    // Registered pin drivers with polarity applied at the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= AN_ACT_LOW ? ~w_onehot : w_onehot;
            r_seg <= SEG_ACT_LOW ? ~w_glyph : w_glyph;
        end
    end

    assign bus.ready = r_ready;
    assign bus.ovf   = r_ovf;
    assign bus.an    = r_an;
    assign bus.seg   = r_seg;

endmodule
